// File: rtl/is_array_ctrl.sv
// is_array_ctrl: run sequencer for an input-stationary systolic PE grid.
// It loads the stationary inputs row by row, then streams k_len weight vectors
// with per-row skew, drains the array and raises per-column capture strobes.
// It also gates the PE fault mask to a bounded window of stream indices.
module is_array_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_W  = 16,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [K_W-1:0]  k_len,
  input  logic [K_W-1:0]  fault_start,
  input  logic [K_W-1:0]  fault_len,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
  output logic            load_we,
  output logic [RW-1:0]   load_row,
  output logic [ROWS-1:0] stream_valid,
  output logic [K_W-1:0]  stream_idx,
  output logic [COLS-1:0] out_valid,
  output logic            fault_en,
  output logic [1:0]      state
);

  // Skew chain length: the last column's strobe lags row 0 by ROWS+COLS-1.
  localparam int SKEW_W = ROWS + COLS - 1;
  localparam logic [K_W-1:0] ROWS_M1  = K_W'(ROWS - 1);
  localparam logic [K_W-1:0] DRAIN_M1 = K_W'(ROWS + COLS - 2);
  localparam logic [K_W-1:0] ONE      = K_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t          cur, nxt;
  logic [K_W-1:0]  cnt, cnt_nxt;
  logic [K_W-1:0]  k_len_q, fault_start_q, fault_len_q;
  logic            load_cfg;
  logic            done_q, done_nxt;
  logic            cfg_err_q, cfg_err_nxt;
  logic            sv0;
  logic            run_abort;
  logic [SKEW_W-1:0] skew_p;
  logic [SKEW_W:0]   taps;
  logic [K_W:0]      fault_end;

  assign run_abort = abort && (cur != IDLE);

  // State, phase counter and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= IDLE;
      cnt       <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cur       <= nxt;
      cnt       <= cnt_nxt;
      done_q    <= done_nxt;
      cfg_err_q <= cfg_err_nxt;
    end
  end

  // Run configuration, captured only when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_len_q       <= '0;
      fault_start_q <= '0;
      fault_len_q   <= '0;
    end else if (load_cfg) begin
      k_len_q       <= k_len;
      fault_start_q <= fault_start;
      fault_len_q   <= fault_len;
    end
  end

  // Next-state logic; abort overrides every non-IDLE transition.
  always_comb begin
    nxt         = cur;
    cnt_nxt     = cnt;
    done_nxt    = 1'b0;
    cfg_err_nxt = 1'b0;
    load_cfg    = 1'b0;
    case (cur)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          if (k_len != '0) begin
            nxt      = LOAD;
            load_cfg = 1'b1;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        if (cnt == ROWS_M1) begin
          nxt     = STREAM;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      STREAM: begin
        if (cnt == k_len_q - ONE) begin
          nxt     = DRAIN;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_M1) begin
          nxt      = IDLE;
          cnt_nxt  = '0;
          done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
    endcase
    if (run_abort) begin
      nxt      = IDLE;
      cnt_nxt  = '0;
      done_nxt = 1'b0;
    end
  end

  assign sv0 = (cur == STREAM);

  // Skew chain: tap j is row-0 stream valid delayed j cycles; cleared on abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skew_p <= '0;
    end else if (run_abort) begin
      skew_p <= '0;
    end else begin
      skew_p <= {skew_p[SKEW_W-2:0], sv0};
    end
  end

  assign taps         = {skew_p, sv0};
  assign stream_valid = taps[ROWS-1:0];
  assign out_valid    = taps[ROWS+COLS-1:ROWS];

  // Window end is formed one bit wider so a large fault_len cannot wrap.
  assign fault_end  = {1'b0, fault_start_q} + {1'b0, fault_len_q};
  assign fault_en   = sv0 && (cnt >= fault_start_q) && ({1'b0, cnt} < fault_end);

  assign busy       = (cur != IDLE);
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
  assign load_we    = (cur == LOAD);
  assign load_row   = load_we ? cnt[RW-1:0] : '0;
  assign stream_idx = sv0 ? cnt : '0;
  assign state      = cur;

endmodule

// File: tb/tb_is_array_ctrl.sv
// Scoreboard bench for is_array_ctrl (ROWS=COLS=4, K_W=16): stimulus pushes
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_is_array_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int K_W  = 16;

  typedef enum int {S_BUSY, S_LWE, S_LROW, S_SV, S_OV, S_DONE, S_IDX,
                    S_STATE, S_FAULT, S_CERR} sig_e;

  typedef struct {
    int          cyc;
    int          rel;
    sig_e        sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [K_W-1:0]  k_len = '0;
  logic [K_W-1:0]  fault_start = '0;
  logic [K_W-1:0]  fault_len = '0;
  logic            busy, done, cfg_err, load_we, fault_en;
  logic [1:0]      load_row;
  logic [ROWS-1:0] stream_valid;
  logic [COLS-1:0] out_valid;
  logic [K_W-1:0]  stream_idx;
  logic [1:0]      state;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  is_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .k_len(k_len),
    .fault_start(fault_start), .fault_len(fault_len), .busy(busy),
    .done(done), .cfg_err(cfg_err), .load_we(load_we), .load_row(load_row),
    .stream_valid(stream_valid), .stream_idx(stream_idx),
    .out_valid(out_valid), .fault_en(fault_en), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(sig_e s);
    case (s)
      S_BUSY:  return 32'(busy);
      S_LWE:   return 32'(load_we);
      S_LROW:  return 32'(load_row);
      S_SV:    return 32'(stream_valid);
      S_OV:    return 32'(out_valid);
      S_DONE:  return 32'(done);
      S_IDX:   return 32'(stream_idx);
      S_STATE: return 32'(state);
      S_FAULT: return 32'(fault_en);
      default: return 32'(cfg_err);
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; overdue ones fail.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [31:0] act;
        act = get_sig(sb[i].sel);
        n_cmp++;
        if (sb[i].cyc < cyc || act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s.%s rel_cyc=%0d: actual=%0h required=%0h",
                   sb[i].tag, sb[i].sel.name(), sb[i].rel, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(int c, int rel, sig_e s, logic [31:0] e, string tag);
    exp_t x;
    x.cyc = c; x.rel = rel; x.sel = s; x.exp = e; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived timeline of a k_len=3 run starting in relative cycle 0;
  // fault_en expected high for relative cycles flo..fhi.
  task automatic push_nominal(int base, int last, int flo, int fhi, string tag);
    for (int k = 0; k <= last; k++) begin
      logic [31:0] sv, ov, st;
      sv = 0; ov = 0;
      for (int r = 0; r < ROWS; r++) if (k >= 5 + r && k <= 7 + r) sv[r] = 1'b1;
      for (int c = 0; c < COLS; c++) if (k >= 9 + c && k <= 11 + c) ov[c] = 1'b1;
      if (k >= 1 && k <= 4) st = 1;
      else if (k >= 5 && k <= 7) st = 2;
      else if (k >= 8 && k <= 14) st = 3;
      else st = 0;
      push(base + k, k, S_BUSY,  32'(k >= 1 && k <= 14), tag);
      push(base + k, k, S_LWE,   32'(k >= 1 && k <= 4), tag);
      push(base + k, k, S_LROW,  (k >= 1 && k <= 4) ? 32'(k - 1) : 32'd0, tag);
      push(base + k, k, S_SV,    sv, tag);
      push(base + k, k, S_OV,    ov, tag);
      push(base + k, k, S_DONE,  32'(k == 15), tag);
      push(base + k, k, S_IDX,   (k >= 5 && k <= 7) ? 32'(k - 5) : 32'd0, tag);
      push(base + k, k, S_STATE, st, tag);
      push(base + k, k, S_FAULT, 32'(k >= flo && k <= fhi), tag);
      push(base + k, k, S_CERR,  32'd0, tag);
    end
  endtask

  task automatic push_quiet(int base, int from, int to, string tag);
    for (int k = from; k <= to; k++) begin
      push(base + k, k, S_BUSY,  32'd0, tag);
      push(base + k, k, S_LWE,   32'd0, tag);
      push(base + k, k, S_SV,    32'd0, tag);
      push(base + k, k, S_OV,    32'd0, tag);
      push(base + k, k, S_DONE,  32'd0, tag);
      push(base + k, k, S_STATE, 32'd0, tag);
      push(base + k, k, S_FAULT, 32'd0, tag);
    end
  endtask

  task automatic go(logic [K_W-1:0] kl, logic [K_W-1:0] fs, logic [K_W-1:0] fl,
                    logic ab, output int base);
    k_len = kl; fault_start = fs; fault_len = fl;
    start = 1'b1; abort = ab;
    base = cyc;
  endtask

  initial begin
    int base;
    // Reset state
    tick();
    push(cyc, 0, S_STATE, 32'd0, "reset");
    push(cyc, 0, S_SV, 32'd0, "reset");
    push(cyc, 0, S_CERR, 32'd0, "reset");
    push(cyc, 0, S_DONE, 32'd0, "reset");
    tick();
    rst = 1'b0;
    tick();

    // 1: nominal run
    go(16'd3, 16'd0, 16'd0, 1'b0, base);
    push_nominal(base, 16, 99, -1, "run1");
    tick(); start = 1'b0;
    repeat (18) tick();

    // 2: one-cycle fault window, with a simultaneous abort in IDLE
    go(16'd3, 16'd1, 16'd1, 1'b1, base);
    push_nominal(base, 16, 6, 6, "fault1");
    tick(); start = 1'b0; abort = 1'b0;
    repeat (18) tick();

    // 3: huge fault_len must not wrap
    go(16'd3, 16'd2, 16'hFFFF, 1'b0, base);
    push_nominal(base, 16, 7, 7, "nowrap");
    tick(); start = 1'b0;
    repeat (18) tick();

    // 4: rejected start
    go(16'd0, 16'd0, 16'd0, 1'b0, base);
    for (int k = 0; k <= 4; k++) push(base + k, k, S_CERR, 32'(k == 1), "kzero");
    push_quiet(base, 0, 4, "kzero");
    tick(); start = 1'b0;
    repeat (6) tick();

    // 5: restart ignored while busy, then abort in STREAM
    go(16'd8, 16'd0, 16'd0, 1'b0, base);
    for (int k = 5; k <= 7; k++) begin
      push(base + k, k, S_STATE, 32'd2, "abort");
      push(base + k, k, S_IDX, 32'(k - 5), "abort");
    end
    push_quiet(base, 8, 20, "abort");
    tick(); start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick(); start = 1'b0; abort = 1'b1;
    tick(); abort = 1'b0;
    repeat (14) tick();

    // 6: reset mid-DRAIN, then a fresh run
    go(16'd3, 16'd0, 16'd0, 1'b0, base);
    push_nominal(base, 9, 99, -1, "rstmid");
    tick(); start = 1'b0;
    repeat (9) tick();
    push_quiet(base, 10, 16, "rstmid");
    for (int k = 10; k <= 16; k++) push(base + k, k, S_CERR, 32'd0, "rstmid");
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    go(16'd3, 16'd0, 16'd0, 1'b0, base);
    push_nominal(base, 16, 99, -1, "rerun");
    tick(); start = 1'b0;
    repeat (18) tick();

    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
